// File: rtl/phy_mem_ctrl_pkg.sv
// Shared memory constants: address map, FSM encoding, UART status bits.
// The UART block is built only when PHY_MEM_UART_EN is defined.
package phy_mem_ctrl_pkg;

  localparam logic [31:0] SRAM_LAST      = 32'h003F_FFFF;
  localparam logic [31:0] UART_DATA_ADDR = 32'h1FD0_03F8;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1FD0_03FC;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_OVERFLOW = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR_PULSE   = 2'd1,
    WR_RECOVER = 2'd2,
    TX_WAIT    = 2'd3
  } state_t;

  function automatic logic is_sram(input logic [31:0] a);
    return a <= SRAM_LAST;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO; a push when full is accepted only alongside a pop.
// Head reads as zero while empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/phy_mem_ctrl.sv
// Physical memory controller: async SRAM port plus optional UART registers.
// Define PHY_MEM_UART_EN to build the UART data/status registers and RX FIFO.
module phy_mem_ctrl
  import phy_mem_ctrl_pkg::*;
#(
  parameter int SRAM_WR_CYCLES = 2,
  parameter int RX_FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        is_write,
  output logic [31:0] data_out,
  output logic        busy,
  output logic [19:0] sram_addr,
  inout  wire  [31:0] sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid
);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  wr_cnt;
  logic [19:0] wr_addr;
  logic [31:0] wr_data;
  logic        idle;
  logic        sram_hit;
  logic        data_hit;
  logic        stat_hit;
  logic        start_sram;
  logic        tx_wr;
  logic        tx_defer;
  logic        tx_free;
  logic        wr_last;
  logic        drive;
  logic [31:0] stat_word;
  logic [31:0] fifo_word;

  assign idle       = state == IDLE;
  assign sram_hit   = is_sram(addr);
  assign start_sram = idle && is_write && sram_hit;
  assign tx_wr      = idle && is_write && data_hit;
  assign tx_defer   = tx_wr && uart_tx_busy;
  assign wr_last    = wr_cnt == 4'(SRAM_WR_CYCLES - 1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          start_sram: state_nx = WR_PULSE;
          tx_defer:   state_nx = TX_WAIT;
          default:    ;
        endcase
      end
      WR_PULSE:   if (wr_last) state_nx = WR_RECOVER;
      WR_RECOVER: state_nx = IDLE;
      TX_WAIT:    if (tx_free) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (start_sram) begin
      wr_cnt  <= '0;
      wr_addr <= addr[21:2];
      wr_data <= data_in;
    end else if (state == WR_PULSE) begin
      wr_cnt  <= wr_cnt + 4'd1;
    end
  end

  // Recovery keeps the bus driven so data hold time follows we_n rising.
  assign drive     = (state == WR_PULSE) || (state == WR_RECOVER);
  assign busy      = !idle;
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = drive;
  assign sram_we_n = state != WR_PULSE;
  assign sram_addr = drive ? wr_addr : addr[21:2];
  assign sram_data = drive ? wr_data : 'z;

  always_comb begin
    data_out = '0;
    unique case (1'b1)
      sram_hit: data_out = sram_data;
      data_hit: data_out = fifo_word;
      stat_hit: data_out = stat_word;
      default:  ;
    endcase
  end

`ifdef PHY_MEM_UART_EN
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        overflow;
  logic [31:0] prev_addr;
  logic [7:0]  rx_head;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_pop;

  assign data_hit = addr == UART_DATA_ADDR;
  assign stat_hit = addr == UART_STAT_ADDR;
  assign tx_free  = !uart_tx_busy;
  // Pop once per visit: only the first cycle of a run of data reads.
  assign rx_pop   = data_hit && !is_write && (prev_addr != UART_DATA_ADDR);

  uart_rx_fifo #(
    .DEPTH(RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (uart_rx_valid),
    .push_data(uart_rx_data),
    .pop      (rx_pop),
    .head     (rx_head),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow   <= 1'b0;
      prev_addr  <= '0;
    end else begin
      prev_addr  <= addr;
      tx_start_q <= tx_wr && !uart_tx_busy;
      if (tx_wr) tx_data_q <= data_in[7:0];
      if (uart_rx_valid && rx_full && !rx_pop)
        overflow <= 1'b1;
      else if (idle && is_write && stat_hit)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    stat_word = '0;
    stat_word[STAT_TX_READY] = !uart_tx_busy && (state != TX_WAIT);
    stat_word[STAT_RX_AVAIL] = !rx_empty;
    stat_word[STAT_OVERFLOW] = overflow;
  end

  assign fifo_word     = {24'h0, rx_head};
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_start = !rst &&
    (tx_start_q || ((state == TX_WAIT) && !uart_tx_busy));
`else
  logic                           unused_uart;
  logic [$clog2(RX_FIFO_DEPTH):0] unused_depth;

  assign data_hit      = 1'b0;
  assign stat_hit      = 1'b0;
  assign tx_free       = 1'b1;
  assign stat_word     = '0;
  assign fifo_word     = '0;
  assign uart_tx_data  = '0;
  assign uart_tx_start = 1'b0;
  assign unused_depth  = '0;
  assign unused_uart   = ^{uart_rx_data, uart_rx_valid, tx_defer};
`endif

endmodule

// File: tb/tb_phy_mem_ctrl.sv
// Self-checking bench for phy_mem_ctrl with a behavioural async SRAM.
// UART checks follow whether PHY_MEM_UART_EN is defined.
module tb_phy_mem_ctrl;

  localparam logic [31:0] DATA_A = 32'h1FD0_03F8;
  localparam logic [31:0] STAT_A = 32'h1FD0_03FC;
  localparam logic [31:0] GAP_A  = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        is_write;
  logic [31:0] data_out;
  logic        busy;
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;

  phy_mem_ctrl #(
    .SRAM_WR_CYCLES(2),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .data_in      (data_in),
    .is_write     (is_write),
    .data_out     (data_out),
    .busy         (busy),
    .sram_addr    (sram_addr),
    .sram_data    (sram_data),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .uart_tx_data (uart_tx_data),
    .uart_tx_start(uart_tx_start),
    .uart_tx_busy (uart_tx_busy),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 256 words, power-up pattern A50000xx.
  logic [31:0] mem [256];
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n)
                   ? mem[sram_addr[7:0]] : 'z;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (!sram_we_n && !sram_ce_n) begin
      mem[sram_addr[7:0]] <= sram_data;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb [$];
  vec_t vecs [10];
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string name);
    sb_t it;
    step();
    addr = a;
    is_write = 1'b0;
    sb.push_back('{name, exp});
    @(negedge clk);
    it = sb.pop_front();
    chk(it.name, data_out, it.exp);
  endtask

  task automatic gap();
    step();
    addr = GAP_A;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step();
    addr = a;
    data_in = d;
    is_write = 1'b1;
    step();
    is_write = 1'b0;
    for (int i = 0; i < 40 && busy; i++) step();
    if (busy) chk("wr_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_rx(input logic [7:0] b);
    step();
    uart_rx_valid = 1'b1;
    uart_rx_data = b;
    step();
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    int busy_n;
    int we_n;
    int starts;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    addr = GAP_A;
    data_in = '0;
    is_write = 1'b0;
    uart_tx_busy = 1'b0;
    uart_rx_data = '0;
    uart_rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd0);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd0);
    chk("rst_tx_start", 32'(uart_tx_start), 32'd0);

    // Write DEADBEEF to 0x10 and trace the strobe timing.
    step();
    addr = 32'h10;
    data_in = 32'hDEAD_BEEF;
    is_write = 1'b1;
    step();
    is_write = 1'b0;
    addr = GAP_A;
    busy_n = 0;
    we_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (!sram_we_n) begin
        we_n++;
        chk("wr_saddr", 32'(sram_addr), 32'h4);
        chk("wr_bus", sram_data, 32'hDEAD_BEEF);
        chk("wr_oe_n", 32'(sram_oe_n), 32'd1);
      end
      step();
    end
    chk("wr_busy_cycles", 32'(busy_n), 32'd3);
    chk("wr_we_cycles", 32'(we_n), 32'd2);
    rd(32'h10, 32'hDEAD_BEEF, "rd_deadbeef");
    chk("rd_busy", 32'(busy), 32'd0);

    wr(32'h0, 32'h1234_5678);
    wr(32'h003F_FFFC, 32'hCAFE_F00D);

    // is_write held into the busy window must be ignored.
    step();
    addr = 32'h30;
    data_in = 32'h1111_2222;
    is_write = 1'b1;
    step();
    addr = 32'h34;
    data_in = 32'h3333_4444;
    step();
    is_write = 1'b0;
    for (int i = 0; i < 10 && busy; i++) step();
    rd(32'h30, 32'h1111_2222, "viol_first");
    rd(32'h34, 32'hA500_000D, "viol_ignored");

    // Unmapped write: no busy.
    step();
    addr = GAP_A;
    data_in = 32'h5555_5555;
    is_write = 1'b1;
    step();
    is_write = 1'b0;
    @(negedge clk);
    chk("unmap_wr_busy", 32'(busy), 32'd0);

    vecs[0] = '{"tbl_w0",     32'h0000_0000, 32'h1234_5678};
    vecs[1] = '{"tbl_w4",     32'h0000_0010, 32'hDEAD_BEEF};
    vecs[2] = '{"tbl_top",    32'h003F_FFFC, 32'hCAFE_F00D};
    vecs[3] = '{"tbl_pat8",   32'h0000_0020, 32'hA500_0008};
    vecs[4] = '{"tbl_pat9",   32'h0000_0024, 32'hA500_0009};
    vecs[5] = '{"tbl_unm_hi", 32'h0040_0000, 32'h0};
    vecs[6] = '{"tbl_unm_f",  32'hFFFF_FFFF, 32'h0};
    vecs[7] = '{"tbl_unm_nr", 32'h1FD0_03F4, 32'h0};
    vecs[8] = '{"tbl_pat40",  32'h0000_0100, 32'hA500_0040};
    vecs[9] = '{"tbl_unm_1f", 32'h1FD0_0400, 32'h0};
    for (int i = 0; i < 10; i++) begin
      rd(vecs[i].a, vecs[i].exp, vecs[i].name);
      chk({vecs[i].name, "_sa"}, 32'(sram_addr), 32'(vecs[i].a[21:2]));
    end

`ifdef PHY_MEM_UART_EN
    rd(STAT_A, 32'h1, "stat_reset");

    // Immediate transmit.
    step();
    addr = DATA_A;
    data_in = 32'h0000_015A;
    is_write = 1'b1;
    step();
    is_write = 1'b0;
    addr = GAP_A;
    @(negedge clk);
    chk("tx_now_start", 32'(uart_tx_start), 32'd1);
    chk("tx_now_data", 32'(uart_tx_data), 32'h5A);
    chk("tx_now_busy", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    chk("tx_now_single", 32'(uart_tx_start), 32'd0);

    // Deferred transmit: tx_busy high 5 cycles.
    step();
    uart_tx_busy = 1'b1;
    addr = DATA_A;
    data_in = 32'h0000_0141;
    is_write = 1'b1;
    step();
    is_write = 1'b0;
    addr = GAP_A;
    busy_n = 0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) uart_tx_busy = 1'b0;
      @(negedge clk);
      if (busy) busy_n++;
      if (uart_tx_start) begin
        starts++;
        chk("txw_data", 32'(uart_tx_data), 32'h41);
        chk("txw_cycle", 32'(i), 32'd4);
      end
      step();
    end
    chk("txw_busy_cycles", 32'(busy_n), 32'd5);
    chk("txw_starts", 32'(starts), 32'd1);

    // Overflow: five pushes into four entries.
    gap();
    uart_tx_busy = 1'b1;
    for (int i = 1; i <= 5; i++) push_rx(8'(i));
    rd(STAT_A, 32'h6, "stat_ovf");
    gap();
    uart_tx_busy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rd(DATA_A, 32'(i), "fifo_pop");
      gap();
    end
    rd(DATA_A, 32'h0, "fifo_empty");
    rd(STAT_A, 32'h5, "stat_ovf_empty");
    wr(STAT_A, 32'h0);
    rd(STAT_A, 32'h1, "stat_cleared");

    // Holding the data address pops only once.
    gap();
    push_rx(8'h10);
    push_rx(8'h20);
    rd(DATA_A, 32'h10, "hold_0");
    rd(DATA_A, 32'h20, "hold_1");
    rd(DATA_A, 32'h20, "hold_2");
    gap();
    rd(DATA_A, 32'h20, "hold_re");
    gap();
    rd(DATA_A, 32'h0, "hold_empty");

    // Full FIFO: pop and push on the same edge.
    gap();
    for (int i = 0; i < 4; i++) push_rx(8'hA0 + 8'(i));
    rd(STAT_A, 32'h3, "full_stat");
    gap();
    step();
    addr = DATA_A;
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h77;
    sb.push_back('{"pp_head", 32'hA0});
    @(negedge clk);
    begin
      sb_t it;
      it = sb.pop_front();
      chk(it.name, data_out, it.exp);
    end
    step();
    uart_rx_valid = 1'b0;
    addr = GAP_A;
    rd(STAT_A, 32'h3, "pp_no_ovf");
    for (int i = 1; i < 4; i++) begin
      gap();
      rd(DATA_A, 32'hA0 + 32'(i), "pp_drain");
    end
    gap();
    rd(DATA_A, 32'h77, "pp_new");
    gap();
    rd(DATA_A, 32'h0, "pp_empty");

    // Reset while waiting on the transmitter.
    step();
    uart_tx_busy = 1'b1;
    addr = DATA_A;
    data_in = 32'h33;
    is_write = 1'b1;
    step();
    is_write = 1'b0;
    addr = GAP_A;
    step();
    rst = 1'b1;
    uart_tx_busy = 1'b0;
    @(negedge clk);
    chk("rst_tx_abort", 32'(uart_tx_start), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_busy", 32'(busy), 32'd0);
    chk("rst_tx_start2", 32'(uart_tx_start), 32'd0);
`else
    rd(STAT_A, 32'h0, "nouart_stat");
    rd(DATA_A, 32'h0, "nouart_data");
    step();
    addr = DATA_A;
    data_in = 32'h55;
    is_write = 1'b1;
    @(negedge clk);
    chk("nouart_busy0", 32'(busy), 32'd0);
    step();
    is_write = 1'b0;
    @(negedge clk);
    chk("nouart_busy1", 32'(busy), 32'd0);
    chk("nouart_start", 32'(uart_tx_start), 32'd0);
    chk("nouart_txdata", 32'(uart_tx_data), 32'd0);
`endif

    // Reset in the second write-pulse cycle.
    step();
    addr = 32'h40;
    data_in = 32'h99;
    is_write = 1'b1;
    step();
    is_write = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_pulse", 32'(sram_we_n), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_wr_busy", 32'(busy), 32'd0);
    chk("rst_wr_oe_n", 32'(sram_oe_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
